// File: rtl/axil_mem_slave.sv
// axil_mem_slave -- AXI4-Lite slave backed by a byte-lane RAM.
//
// Storage is DEPTH words of DATA_W bits, built from DATA_W/8 byte-lane
// instances so that write strobes map directly onto per-lane write enables.
// The write and read channels each have their own FSM and run independently.
//
// Parameters:
//   ADDR_W  AXI byte-address width
//   DATA_W  data width, 32 or 64
//   DEPTH   words of storage, power of two, >= 2
//   RD_LAT  cycles from AR acceptance to RVALID, 1..8
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   s_aw*  / s_w* / s_b*         write address / data / response channels
//   s_ar*  / s_r*                read address / data channels
//
// Build option:
//   AXIL_MEM_SLVERR_EN  when defined, addresses beyond DEPTH words get a
//                       SLVERR response: writes are dropped, reads return 0.
//                       When undefined, the upper address bits are ignored
//                       (the address aliases modulo DEPTH) and every response
//                       is OKAY.

module axil_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             aclk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wbyte,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rbyte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge aclk)
    if (we) mem[waddr] <= wbyte;

  // A write committing this cycle is forwarded, so a read that samples the
  // array on the same edge observes the post-write value.
  assign rbyte = (we && (waddr == raddr)) ? wbyte : mem[raddr];
endmodule

module axil_mem_slave #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              aclk,
  input  logic              areset,
  // AW
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  // W
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  // B
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  // AR
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  // R
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = 3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             ok;   // address lies within DEPTH words
  } maddr_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][7:0] data;
    logic [NUM_LANES-1:0]      strb;
  } wbeat_t;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  function automatic logic [1:0] resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  maddr_t aw_dec, ar_dec;

  always_comb begin
    aw_dec.idx = s_awaddr[IDX_W+OFF_W-1:OFF_W];
    ar_dec.idx = s_araddr[IDX_W+OFF_W-1:OFF_W];
`ifdef AXIL_MEM_SLVERR_EN
    aw_dec.ok  = ((s_awaddr >> (IDX_W + OFF_W)) == '0);
    ar_dec.ok  = ((s_araddr >> (IDX_W + OFF_W)) == '0);
`else
    aw_dec.ok  = 1'b1;
    ar_dec.ok  = 1'b1;
`endif
  end

  // Byte-offset bits (and, without SLVERR, the upper bits) play no part.
  logic unused_addr;
  assign unused_addr = ^{s_awaddr, s_araddr};

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  wstate_t    wstate;
  logic       awready_q, wready_q, bvalid_q;
  logic [1:0] bresp_q;
  maddr_t     aw_q;
  wbeat_t     w_q;

  wbeat_t w_in;
  maddr_t wr_addr;
  wbeat_t wr_beat;
  logic   aw_hs, w_hs, commit, mem_we;

  assign w_in.data = s_wdata;
  assign w_in.strb = s_wstrb;

  assign aw_hs = s_awvalid & awready_q;
  assign w_hs  = s_wvalid & wready_q;

  // The write lands on the edge that accepts the second half of the pair;
  // whichever half arrived first is taken from its holding register.
  assign commit = ((wstate == W_IDLE)    & aw_hs & w_hs) |
                  ((wstate == W_HAVE_AW) & w_hs) |
                  ((wstate == W_HAVE_W)  & aw_hs);
  assign wr_addr = (wstate == W_HAVE_AW) ? aw_q : aw_dec;
  assign wr_beat = (wstate == W_HAVE_W)  ? w_q  : w_in;
  assign mem_we  = commit & wr_addr.ok;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate    <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_q      <= '0;
      w_q       <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wstate    <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= resp_of(aw_dec.ok);
          end else if (aw_hs) begin
            wstate    <= W_HAVE_AW;
            aw_q      <= aw_dec;
            awready_q <= 1'b0;
          end else if (w_hs) begin
            wstate    <= W_HAVE_W;
            w_q       <= w_in;
            wready_q  <= 1'b0;
          end else begin
            // Readies are low out of reset and come up here.
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            wstate   <= W_RESP;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= resp_of(aw_q.ok);
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            wstate    <= W_RESP;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= resp_of(aw_dec.ok);
          end
        end
        W_RESP: begin
          if (s_bready) begin
            wstate    <= W_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  rstate_t             rstate;
  logic                arready_q, rvalid_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    rcnt;
  maddr_t              ar_q;

  maddr_t                    rd_addr;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic                      ar_hs;

  assign ar_hs = s_arvalid & arready_q;

  // With RD_LAT=1 the array is sampled on the accepting edge itself, so the
  // live address is used; otherwise the latched one.
  assign rd_addr = (rstate == R_IDLE) ? ar_dec : ar_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rstate    <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rcnt      <= '0;
      ar_q      <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            ar_q      <= ar_dec;
            rcnt      <= CNT_W'(RD_LAT - 1);
            if (RD_LAT == 1) begin
              rstate   <= R_DATA;
              rvalid_q <= 1'b1;
              rdata_q  <= ar_dec.ok ? rd_word : '0;
              rresp_q  <= resp_of(ar_dec.ok);
            end else begin
              rstate   <= R_WAIT;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          // Entered with rcnt >= 1; data is captured as it reaches 0.
          rcnt <= rcnt - 1'b1;
          if (rcnt <= CNT_W'(1)) begin
            rstate   <= R_DATA;
            rvalid_q <= 1'b1;
            rdata_q  <= ar_q.ok ? rd_word : '0;
            rresp_q  <= resp_of(ar_q.ok);
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rstate    <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  // ---------------------------------------------------------------------
  // Storage: one instance per byte lane
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axil_mem_lane #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .aclk  (aclk),
      .we    (mem_we & wr_beat.strb[i]),
      .waddr (wr_addr.idx),
      .wbyte (wr_beat.data[i]),
      .raddr (rd_addr.idx),
      .rbyte (rd_word[i])
    );
  end
endmodule

// File: tb/tb_axil_mem_slave.sv
// Bench for axil_mem_slave: a 32-bit RD_LAT=1 instance (index 0) and a
// 64-bit RD_LAT=4 instance (index 1). Stimulus tasks push the expected B/R
// responses into queues; a monitor pops and compares them whenever the DUT
// presents a response, and also checks response latency and hold stability.
module tb_axil_mem_slave;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

`ifdef AXIL_MEM_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [1:0][15:0] awaddr, araddr;
  logic [1:0]       awvalid, wvalid, bready, arvalid, rready;
  logic [1:0][63:0] wdata;
  logic [1:0][7:0]  wstrb;
  logic [1:0]       awready, wready, bvalid, arready, rvalid;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0][63:0] rdata;

  assign rdata[0][63:32] = '0;
  logic unused_tb;
  assign unused_tb = ^{wdata[0][63:32], wstrb[0][7:4]};

  axil_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .RD_LAT(LAT0)) u_d32 (
    .aclk(aclk), .areset(areset),
    .s_awaddr(awaddr[0]), .s_awvalid(awvalid[0]), .s_awready(awready[0]),
    .s_wdata(wdata[0][31:0]), .s_wstrb(wstrb[0][3:0]), .s_wvalid(wvalid[0]), .s_wready(wready[0]),
    .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready[0]),
    .s_araddr(araddr[0]), .s_arvalid(arvalid[0]), .s_arready(arready[0]),
    .s_rdata(rdata[0][31:0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(rready[0]));

  axil_mem_slave #(.ADDR_W(16), .DATA_W(64), .DEPTH(1024), .RD_LAT(LAT1)) u_d64 (
    .aclk(aclk), .areset(areset),
    .s_awaddr(awaddr[1]), .s_awvalid(awvalid[1]), .s_awready(awready[1]),
    .s_wdata(wdata[1]), .s_wstrb(wstrb[1]), .s_wvalid(wvalid[1]), .s_wready(wready[1]),
    .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready[1]),
    .s_araddr(araddr[1]), .s_arvalid(arvalid[1]), .s_arready(arready[1]),
    .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(rready[1]));

  typedef struct {
    int          d;
    logic [1:0]  resp;
    logic [63:0] data;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake timed out (t=%0t)", nm, $time);
  endtask

  // ---------------------------------------------------------------- monitor
  int   last_w[2];
  int   last_ar[2];
  logic bv_prev[2];
  logic rv_prev[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      last_w[d] = 0; last_ar[d] = 0; bv_prev[d] = 1'b0; rv_prev[d] = 1'b0;
    end
    forever begin
      @(negedge aclk);
      for (int d = 0; d < 2; d++) begin
        if (bvalid[d]) begin
          if (!bv_prev[d]) check("b_latency", 72'(cyc - last_w[d]), 72'd1);
          if (bq.size() == 0) begin
            check("b_unexpected", 72'(bvalid[d]), 72'd0);
          end else begin
            check("bresp", {2'(d), 6'd0, bresp[d], 62'd0},
                  {2'(bq[0].d), 6'd0, bq[0].resp, 62'd0});
            if (bready[d]) void'(bq.pop_front());
          end
        end
        if (rvalid[d]) begin
          if (!rv_prev[d])
            check("r_latency", 72'(cyc - last_ar[d]), 72'(d == 0 ? LAT0 : LAT1));
          if (rq.size() == 0) begin
            check("r_unexpected", 72'(rvalid[d]), 72'd0);
          end else begin
            check("rdata_rresp", {2'(d), 4'd0, rresp[d], rdata[d]},
                  {2'(rq[0].d), 4'd0, rq[0].resp, rq[0].data});
            if (rready[d]) void'(rq.pop_front());
          end
        end
        // Handshake edges: the accepting posedge follows this negedge.
        if ((awvalid[d] && awready[d]) || (wvalid[d] && wready[d])) last_w[d] = cyc;
        if (arvalid[d] && arready[d]) last_ar[d] = cyc;
        bv_prev[d] = bvalid[d];
        rv_prev[d] = rvalid[d];
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic aw_send(input int d, input logic [15:0] a);
    bit ok = 1'b0;
    awaddr[d] = a; awvalid[d] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge aclk); ok = awready[d];
      step();
    end
    awvalid[d] = 1'b0;
    if (!ok) timeout("aw_handshake");
  endtask

  task automatic w_send(input int d, input logic [63:0] v, input logic [7:0] s);
    bit ok = 1'b0;
    wdata[d] = v; wstrb[d] = s; wvalid[d] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge aclk); ok = wready[d];
      step();
    end
    wvalid[d] = 1'b0;
    if (!ok) timeout("w_handshake");
  endtask

  task automatic ar_send(input int d, input logic [15:0] a);
    bit ok = 1'b0;
    araddr[d] = a; arvalid[d] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge aclk); ok = arready[d];
      step();
    end
    arvalid[d] = 1'b0;
    if (!ok) timeout("ar_handshake");
  endtask

  task automatic b_wait(input int d);
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge aclk); ok = bvalid[d] && bready[d];
      step();
    end
    if (!ok) timeout("b_handshake");
  endtask

  task automatic r_wait(input int d);
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge aclk); ok = rvalid[d] && rready[d];
      step();
    end
    if (!ok) timeout("r_handshake");
  endtask

  // mode 0: AW and W together; 1: W three cycles ahead of AW; 2: AW two ahead of W
  task automatic wr_issue(input int d, input logic [15:0] a, input logic [63:0] v,
                          input logic [7:0] s, input int mode, input logic [1:0] er);
    exp_t e;
    e.d = d; e.resp = er; e.data = '0;
    bq.push_back(e);
    case (mode)
      1: fork
           w_send(d, v, s);
           begin step(); step(); step(); aw_send(d, a); end
         join
      2: fork
           aw_send(d, a);
           begin step(); step(); w_send(d, v, s); end
         join
      default: fork
           aw_send(d, a);
           w_send(d, v, s);
         join
    endcase
  endtask

  task automatic wr(input int d, input logic [15:0] a, input logic [63:0] v,
                    input logic [7:0] s, input int mode, input logic [1:0] er);
    wr_issue(d, a, v, s, mode, er);
    b_wait(d);
  endtask

  task automatic rd(input int d, input logic [15:0] a, input logic [63:0] v, input logic [1:0] er);
    exp_t e;
    e.d = d; e.resp = er; e.data = v;
    rq.push_back(e);
    ar_send(d, a);
    r_wait(d);
  endtask

  task automatic rst_outputs_check();
    for (int d = 0; d < 2; d++) begin
      check("rst_readies", {69'd0, awready[d], wready[d], arready[d]}, 72'd0);
      check("rst_valids", {70'd0, bvalid[d], rvalid[d]}, 72'd0);
      check("rst_resp_data", {4'd0, bresp[d], rresp[d], rdata[d]}, 72'd0);
    end
  endtask

  // Pulse reset, then confirm readies stay low until the first edge after
  // release and come up on it (both FSMs back in IDLE).
  task automatic do_reset();
    areset = 1'b1;
    @(negedge aclk);
    rst_outputs_check();
    step();
    areset = 1'b0;
    @(negedge aclk);
    for (int d = 0; d < 2; d++)
      check("ready_before_edge", {69'd0, awready[d], wready[d], arready[d]}, 72'd0);
    step();
    @(negedge aclk);
    for (int d = 0; d < 2; d++)
      check("ready_after_edge", {69'd0, awready[d], wready[d], arready[d]}, 72'b111);
    step();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready = 2'b11; rready = 2'b11;

    repeat (3) step();
    do_reset();

    // ---- 32-bit, RD_LAT=1
    wr(0, 16'h0010, 64'hDEADBEEF, 8'hF, 0, 2'b00);
    rd(0, 16'h0010, 64'hDEADBEEF, 2'b00);
    rd(0, 16'h0013, 64'hDEADBEEF, 2'b00);          // byte offset ignored

    wr(0, 16'h0020, 64'hFFFFFFFF, 8'hF, 0, 2'b00);
    wr(0, 16'h0020, 64'h11223344, 8'h5, 1, 2'b00); // W ahead of AW
    rd(0, 16'h0020, 64'hFF22FF44, 2'b00);

    wr(0, 16'h0024, 64'hCAFEF00D, 8'hF, 2, 2'b00); // AW ahead of W
    wr(0, 16'h0024, 64'h00000000, 8'h0, 0, 2'b00); // empty strobe: still responds
    rd(0, 16'h0024, 64'hCAFEF00D, 2'b00);

    // B held off for 5 cycles
    bready[0] = 1'b0;
    wr_issue(0, 16'h0030, 64'h12345678, 8'hF, 0, 2'b00);
    repeat (5) begin
      @(negedge aclk);
      check("b_hold", {69'd0, bvalid[0], awready[0], wready[0]}, 72'b100);
    end
    step();
    bready[0] = 1'b1;
    b_wait(0);

    // R held off for 5 cycles (monitor re-checks rdata every cycle)
    rready[0] = 1'b0;
    begin
      exp_t e;
      e.d = 0; e.resp = 2'b00; e.data = 64'h12345678;
      rq.push_back(e);
    end
    ar_send(0, 16'h0030);
    repeat (5) begin
      @(negedge aclk);
      check("r_hold", {70'd0, rvalid[0], arready[0]}, 72'b10);
    end
    step();
    rready[0] = 1'b1;
    r_wait(0);

    // out-of-range: 0x1000 is word 1024
    wr(0, 16'h0000, 64'h01020304, 8'hF, 0, 2'b00);
    wr(0, 16'h1000, 64'hAAAA5555, 8'hF, 0, SLV ? 2'b10 : 2'b00);
    rd(0, 16'h0000, SLV ? 64'h01020304 : 64'hAAAA5555, 2'b00);
    rd(0, 16'h1000, SLV ? 64'h0 : 64'hAAAA5555, SLV ? 2'b10 : 2'b00);

    // same-cycle write and read of one word
    fork
      wr(0, 16'h0040, 64'h55667788, 8'hF, 0, 2'b00);
      rd(0, 16'h0040, 64'h55667788, 2'b00);
    join
    wr(0, 16'h0044, 64'h11111111, 8'hF, 0, 2'b00);
    fork
      wr(0, 16'h0044, 64'hAABBCCDD, 8'h6, 0, 2'b00);
      rd(0, 16'h0044, 64'h11BBCC11, 2'b00);
    join

    // reset with only AW accepted: no B, data survives, lone W later is a fresh write
    aw_send(0, 16'h0050);
    do_reset();
    rd(0, 16'h0010, 64'hDEADBEEF, 2'b00);
    wr(0, 16'h0054, 64'h77777777, 8'hF, 1, 2'b00);
    rd(0, 16'h0054, 64'h77777777, 2'b00);

    // ---- 64-bit, RD_LAT=4
    wr(1, 16'h0010, 64'h0123456789ABCDEF, 8'hFF, 0, 2'b00);
    rd(1, 16'h0010, 64'h0123456789ABCDEF, 2'b00);
    wr(1, 16'h0010, 64'hDEADBEEF00000000, 8'hF0, 0, 2'b00);
    rd(1, 16'h0010, 64'hDEADBEEF89ABCDEF, 2'b00);
    rd(1, 16'h0017, 64'hDEADBEEF89ABCDEF, 2'b00);
    wr(1, 16'h0018, 64'h00000000DEADBEEF, 8'hFF, 1, 2'b00);
    rd(1, 16'h0018, 64'h00000000DEADBEEF, 2'b00);
    fork
      wr(1, 16'h0040, 64'h1122334455667788, 8'hFF, 0, 2'b00);
      rd(1, 16'h0040, 64'h1122334455667788, 2'b00);
    join
    wr(1, 16'h0000, 64'h0A0B0C0D0E0F1011, 8'hFF, 0, 2'b00);
    wr(1, 16'h2000, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2, SLV ? 2'b10 : 2'b00);
    rd(1, 16'h0000, SLV ? 64'h0A0B0C0D0E0F1011 : 64'h0A0B0C0DFFFFFFFF, 2'b00);

    // reset during the read wait: no R, data survives
    ar_send(1, 16'h0010);
    do_reset();
    rd(1, 16'h0010, 64'hDEADBEEF89ABCDEF, 2'b00);

    repeat (10) step();
    check("queues_drained", 72'(bq.size() + rq.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_mem_slave.md
AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, AXI-Lite byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DATA_W words of storage; must be a power of two.
REQ-004 SHALL have parameter RD_LAT, default 1, cycles from AR acceptance to RVALID; legal range 1..8.
REQ-005 SHALL have port aclk, input, 1 bit, sole clock; all logic samples on its rising edge.
REQ-006 SHALL have port areset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have the AW channel: s_awaddr in ADDR_W; s_awvalid in 1; s_awready out 1.
REQ-008 SHALL have the W channel: s_wdata in DATA_W; s_wstrb in DATA_W/8; s_wvalid in 1; s_wready out 1.
REQ-009 SHALL have the B channel: s_bresp out 2; s_bvalid out 1; s_bready in 1.
REQ-010 SHALL have the AR channel: s_araddr in ADDR_W; s_arvalid in 1; s_arready out 1.
REQ-011 SHALL have the R channel: s_rdata out DATA_W; s_rresp out 2; s_rvalid out 1; s_rready in 1.

Function
REQ-012 Word index SHALL be addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
REQ-013 An address is in range when addr >> log2(DATA_W/8) < DEPTH; when DEPTH words do not fill ADDR_W, the upper bits are compared.
REQ-014 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
REQ-015 In W_IDLE, AW and W SHALL be accepted independently: AW only -> W_HAVE_AW; W only -> W_HAVE_W; both in the same cycle -> W_RESP.
REQ-016 s_awready SHALL be high in W_IDLE and W_HAVE_W only; s_wready SHALL be high in W_IDLE and W_HAVE_AW only.
REQ-017 The memory write SHALL occur in the cycle the second of the AW/W pair is accepted; only bytes with s_wstrb[i]=1 are updated; wstrb=0 writes nothing but still responds.
REQ-018 In W_RESP, s_bvalid SHALL be 1 and s_bresp SHALL hold stable until s_bready; then return to W_IDLE. Minimum AW-to-BVALID latency is 1 cycle.
REQ-019 Read FSM SHALL have states R_IDLE, R_WAIT and R_DATA; s_arready SHALL be 1 only in R_IDLE.
REQ-020 On AR handshake, the address SHALL be latched and a counter loaded with RD_LAT-1; R_WAIT decrements the counter to 0, then enters R_DATA (RD_LAT=1 goes directly to R_DATA).
REQ-021 In R_DATA, s_rvalid=1, and s_rdata/s_rresp SHALL be stable until s_rready, then return to R_IDLE.
REQ-022 Read and write FSMs SHALL be independent. On a same-cycle write and read of the same word, the read SHALL return the data after the write.
REQ-023 s_bresp and s_rresp SHALL be 2'b00 (OKAY) except as defined in REQ-026/027.

Reset
REQ-024 On areset=1, asynchronously: both FSMs go to IDLE; s_awready=s_wready=s_arready=0 while reset is asserted; s_bvalid=s_rvalid=0; s_bresp=s_rresp=0; s_rdata=0.
REQ-025 Memory contents SHALL NOT be cleared by reset. A transaction in flight at reset is discarded with no B/R response. Ready signals rise on the first clock edge after reset release.

Configuration
REQ-026 With macro AXIL_MEM_SLVERR_EN defined: an out-of-range write SHALL not modify memory and SHALL return bresp=2'b10 (SLVERR); an out-of-range read SHALL return rresp=2'b10 and rdata=0.
REQ-027 Without AXIL_MEM_SLVERR_EN: out-of-range addresses SHALL alias modulo DEPTH (upper bits ignored), and responses are always OKAY.

Verification
REQ-028 Write 0x10 <- 0xDEADBEEF with strb 0xF (AW and W in the same cycle), then read 0x10 -> rdata 0xDEADBEEF, rresp 0, and RVALID exactly RD_LAT cycles after AR handshake (check RD_LAT=1 and 4).
REQ-029 W presented 3 cycles before AW, then AW at 0x20 -> a single write and bvalid 1 cycle after AW acceptance; strb 0x5 over 0xFFFFFFFF with data 0x11223344 -> read 0xFF22FF44.
REQ-030 bready held low 5 cycles -> bvalid/bresp stable, awready=0 throughout; rready low -> rdata stable.
REQ-031 DEPTH=1024, DATA_W=32, write 0x1000: with SLVERR_EN -> bresp 2'b10 and word 0 unchanged; without -> word 0 overwritten, bresp 0.
REQ-032 Assert areset during R_WAIT and during W_HAVE_AW -> rvalid and bvalid stay 0, IDLE after release, and earlier-written data is still readable.
REQ-033 Concurrent write and read of 0x40 in the same cycle -> the read returns the new data; a DATA_W=64 run exercises strb 0xF0 on the upper word half.
